fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and drives the byte address into the combinational instruction memory (`imem`, ports `pc_addr` → `instr`). It captures the returned instruction into the IF/ID pipeline register for the decode stage. It also applies hazard-unit stalls and branch/jump redirects, which flush the fetched instruction.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/pc_reg.sv | 44 ++++
 rtl/fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, bubble encoding, default
// reset vector, PC increment and the fetch-stage action decode.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] MIPS_NOP         = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        FETCH_RESET    = 2'd0,
        FETCH_REDIRECT = 2'd1,
        FETCH_STALL    = 2'd2,
        FETCH_ADVANCE  = 2'd3
    } fetch_act_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    // Edge action with priority rst > redirect > stall > advance.
    function automatic fetch_act_e fetch_action(input logic rst,
                                                input logic redirect,
                                                input logic stall);
        if (rst)           return FETCH_RESET;
        else if (redirect) return FETCH_REDIRECT;
        else if (stall)    return FETCH_STALL;
        else               return FETCH_ADVANCE;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, word-aligned load, hold, or +4 with
// natural 32-bit wrap.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            hold_i,
    output logic [XLEN-1:0] pc_o
);

    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Low target bits are dropped so the PC stays word-aligned.
    logic unused_load_lsb;
    assign unused_load_lsb = &{1'b0, load_pc_i[1:0]};

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {load_pc_i[XLEN-1:2], 2'b00};
        end else if (!hold_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, stall and redirect/flush.
// Optional performance counters are enabled with macro FETCH_PERF_EN.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_addr,
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
`endif
);

    fetch_act_e      act;
    logic [XLEN-1:0] pc_q;
    if_id_t          if_id_q;
    if_id_t          if_id_d;

    assign act = fetch_action(rst, redirect, stall);

    // Redirect wins over stall inside pc_reg because load outranks hold.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .hold_i    (stall),
        .pc_o      (pc_q)
    );

    always_comb begin
        if_id_d = if_id_q;
        case (act)
            FETCH_RESET, FETCH_REDIRECT: begin
                if_id_d.instr = NOP_INSTR;
                if_id_d.pc4   = '0;
                if_id_d.valid = 1'b0;
            end
            FETCH_STALL: begin
                if_id_d = if_id_q;
            end
            FETCH_ADVANCE: begin
                if_id_d.instr = instr;
                if_id_d.pc4   = pc_q + PC_INC;
                if_id_d.valid = 1'b1;
            end
            default: begin
                if_id_d = if_id_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if_id_q <= if_id_d;
    end

    assign pc_addr     = pc_q;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (act)
            FETCH_RESET: begin
                fetch_cnt_d = '0;
                stall_cnt_d = '0;
                flush_cnt_d = '0;
            end
            FETCH_REDIRECT: flush_cnt_d = flush_cnt_q + 1'b1;
            FETCH_STALL:    stall_cnt_d = stall_cnt_q + 1'b1;
            FETCH_ADVANCE:  fetch_cnt_d = fetch_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        fetch_cnt_q <= fetch_cnt_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
